fifo_uart_tx: RTL

Downstream drain stage for `sync_fifo`. It pops bytes from the FIFO read port whenever the FIFO is non-empty and transmission is enabled, and serializes each byte as an 8N1 UART frame on a single TX line. One frame is in flight at a time. The FIFO absorbs burst writes from upstream logic, and this block emits them at the configured baud rate.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: FSM state encoding (3 bits) and the bit-period helper.
package fifo_uart_pkg;

  // Transmitter FSM states; the values are fixed so waveforms stay readable
  // across builds.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_START = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6
  } tx_state_t;

  // Clocks per UART bit. Integer division truncates, so the real baud rate
  // is slightly above the nominal one when the ratio is not exact.
  function automatic int calc_baud_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: free-runs 0..BAUD_CNT-1 while run is high, tick on the last count.
// Latency: tick is combinational from the counter, one cycle wide per bit period.
// Backpressure: none; clear has priority over run and restarts the period.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronously zero the counter
//   run        : advance the counter this cycle
//   tick       : high for the cycle at which the count is BAUD_CNT-1
module uart_baud_tick #(
  parameter int BAUD_CNT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] LAST = CW'(BAUD_CNT - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      // The wrap back to zero is the bit boundary.
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync FIFO one word at a time and serialises each word as an 8N1-style UART frame.
// Latency: rden 1 cycle after empty is seen low, start bit 3 cycles after rden; frame = (DATA_WIDTH+2)*BAUD_CNT.
// Backpressure: pops only when idle, enabled and non-empty; one frame in flight, started frames always finish.
//
// Ports:
//   i_sys_clk, i_sys_rst_n : clock, asynchronous active-low reset (aborts any frame)
//   i_tx_en                : allow fetching new words
//   i_empty / o_rden       : FIFO empty flag / one-cycle registered read strobe
//   i_rdata                : FIFO read data, valid the cycle after o_rden
//   o_uart_txd             : serial line, idles high
//   o_busy                 : high in every state except idle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_tx_en,
  input  logic                  i_empty,
  output logic                  o_rden,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_uart_txd,
  output logic                  o_busy
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  // A one-clock bit period cannot give a distinct tick per bit.
  generate
    if (BAUD_CNT < 2) begin : g_baud_chk
      $error("fifo_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  baud_clear;
  logic                  baud_run;
  logic                  baud_tick;

  // The bit timer restarts in LOAD so the start bit gets a full period.
  assign baud_clear = (state == ST_LOAD);
  assign baud_run   = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

  uart_baud_tick #(
    .BAUD_CNT(BAUD_CNT)
  ) u_baud_tick (
    .clk  (i_sys_clk),
    .rst_n(i_sys_rst_n),
    .clear(baud_clear),
    .run  (baud_run),
    .tick (baud_tick)
  );

  // Line, strobe and busy are all registered so the FIFO and the pad see
  // glitch-free outputs; each is set on the transition into its state.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state      <= ST_IDLE;
      o_rden     <= 1'b0;
      o_uart_txd <= 1'b1;
      o_busy     <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      o_rden <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_tx_en && !i_empty) begin
            state  <= ST_FETCH;
            o_rden <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        // FIFO presents the popped word during this cycle.
        ST_WAIT:  state <= ST_LOAD;
        ST_LOAD: begin
          shreg      <= i_rdata;
          bit_cnt    <= '0;
          o_uart_txd <= 1'b0;
          state      <= ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            o_uart_txd <= shreg[0];
            shreg      <= {1'b0, shreg[DATA_WIDTH-1:1]};
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              o_uart_txd <= 1'b1;
              state      <= ST_STOP;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              o_uart_txd <= shreg[0];
              shreg      <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          o_uart_txd <= 1'b1;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
